// File: rtl/de_selector14_sched_pkg.sv
// Shared definitions for the de_selector14 round-robin scheduler:
// state encodings, requester count and the round-robin pick function.
package de_selector14_sched_pkg;

   localparam int N_REQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Walk from the farthest candidate (lp itself) toward lp+1 so the nearest requester wins.
   function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] lp);
      logic [1:0] idx;
      logic [1:0] pick;
      pick = lp;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = lp + 2'(i);
         if (req[idx]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/de_selector14_sched_demux.sv
// 1-to-4 demultiplexer: routes iC to the output addressed by {iS1,iS0}, all others 0.
module de_selector14 (
   input  logic iC,
   input  logic iS1,
   input  logic iS0,
   output logic oZ0,
   output logic oZ1,
   output logic oZ2,
   output logic oZ3
);

   assign oZ0 = iC & ~iS1 & ~iS0;
   assign oZ1 = iC & ~iS1 &  iS0;
   assign oZ2 = iC &  iS1 & ~iS0;
   assign oZ3 = iC &  iS1 &  iS0;

endmodule

// File: rtl/de_selector14_sched.sv
// Round-robin, time-limited scheduler sharing serial source iC among four consumers,
// with a one-cycle break-before-make gap between grants.
module de_selector14_sched
   import de_selector14_sched_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 3
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iC,
   input  logic [3:0] iReq,
   output logic [3:0] oGnt,
   output logic       oGrantValid,
   output logic       oS1,
   output logic       oS0,
   output logic       oZ0,
   output logic       oZ1,
   output logic       oZ2,
   output logic       oZ3
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       lp;
   logic [1:0]       sel;
   logic [1:0]       pick;
   logic             any_req;
   logic             gated_c;

   assign pick    = rr_pick(iReq, lp);
   assign any_req = |iReq;

   // Select lines only change on a new grant, so they hold through GAP and IDLE.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state       <= ST_IDLE;
         oGnt        <= 4'b0000;
         oGrantValid <= 1'b0;
         sel         <= 2'd0;
         cnt         <= '0;
         lp          <= 2'd3;
      end else begin
         case (state)
            ST_IDLE, ST_GAP: begin
               cnt <= '0;
               if (any_req) begin
                  state       <= ST_GRANT;
                  oGnt        <= 4'(1) << pick;
                  oGrantValid <= 1'b1;
                  sel         <= pick;
                  lp          <= pick;
               end else begin
                  state       <= ST_IDLE;
                  oGnt        <= 4'b0000;
                  oGrantValid <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (!iReq[sel] || cnt == CNT_LAST) begin
                  state       <= ST_GAP;
                  oGnt        <= 4'b0000;
                  oGrantValid <= 1'b0;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state       <= ST_IDLE;
               oGnt        <= 4'b0000;
               oGrantValid <= 1'b0;
               cnt         <= '0;
            end
         endcase
      end
   end

   assign oS1     = sel[1];
   assign oS0     = sel[0];
   assign gated_c = iC & oGrantValid;

   de_selector14 u_demux (
      .iC  (gated_c),
      .iS1 (sel[1]),
      .iS0 (sel[0]),
      .oZ0 (oZ0),
      .oZ1 (oZ1),
      .oZ2 (oZ2),
      .oZ3 (oZ3)
   );

endmodule

// File: tb/tb_de_selector14_sched.sv
// Directed scoreboard bench for de_selector14_sched, covering HOLD_CYCLES=4 and HOLD_CYCLES=1.
module tb_de_selector14_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       c;
   logic [3:0] req4;
   logic [3:0] req1;

   logic [3:0] gnt4, gnt1;
   logic       valid4, valid1;
   logic       s1_4, s0_4, s1_1, s0_1;
   logic       z0_4, z1_4, z2_4, z3_4;
   logic       z0_1, z1_1, z2_1, z3_1;

   int tests    = 0;
   int failures = 0;

   typedef struct packed {
      logic       use1;
      logic [3:0] gnt;
      logic [1:0] s;
      logic       valid;
      logic [3:0] z;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   de_selector14_sched #(.HOLD_CYCLES(4), .CNT_W(3)) dut4 (
      .iClk(clk), .iRst(rst), .iC(c), .iReq(req4),
      .oGnt(gnt4), .oGrantValid(valid4), .oS1(s1_4), .oS0(s0_4),
      .oZ0(z0_4), .oZ1(z1_4), .oZ2(z2_4), .oZ3(z3_4)
   );

   de_selector14_sched #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (
      .iClk(clk), .iRst(rst), .iC(c), .iReq(req1),
      .oGnt(gnt1), .oGrantValid(valid1), .oS1(s1_1), .oS0(s0_1),
      .oZ0(z0_1), .oZ1(z1_1), .oZ2(z2_1), .oZ3(z3_1)
   );

   // Expected z follows from the grant: only the granted output carries iC.
   task automatic pushExp(input logic use1, input logic [3:0] eg, input logic [1:0] es);
      exp_t e;
      e.use1  = use1;
      e.gnt   = eg;
      e.s     = es;
      e.valid = (eg != 4'b0000);
      e.z     = c ? eg : 4'b0000;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic [3:0] og, oz;
      logic [1:0] os;
      logic       ov;
      if (sb.size() == 0) begin
         tests++;
         failures++;
         $error("[TB] FAIL scoreboard_empty at %0t", $time);
         return;
      end
      e = sb.pop_front();
      if (e.use1) begin
         og = gnt1; os = {s1_1, s0_1}; ov = valid1; oz = {z3_1, z2_1, z1_1, z0_1};
      end else begin
         og = gnt4; os = {s1_4, s0_4}; ov = valid4; oz = {z3_4, z2_4, z1_4, z0_4};
      end
      tests++;
      assert (og === e.gnt) else begin
         failures++;
         $error("[TB] FAIL gnt dut%0d t=%0t observed=%b expected=%b", e.use1 ? 1 : 4, $time, og, e.gnt);
      end
      tests++;
      assert (os === e.s) else begin
         failures++;
         $error("[TB] FAIL sel dut%0d t=%0t observed=%b expected=%b", e.use1 ? 1 : 4, $time, os, e.s);
      end
      tests++;
      assert (ov === e.valid) else begin
         failures++;
         $error("[TB] FAIL valid dut%0d t=%0t observed=%b expected=%b", e.use1 ? 1 : 4, $time, ov, e.valid);
      end
      tests++;
      assert (oz === e.z) else begin
         failures++;
         $error("[TB] FAIL z dut%0d t=%0t observed=%b expected=%b", e.use1 ? 1 : 4, $time, oz, e.z);
      end
   endtask

   // Drive inputs, record the expectation, then check just after the next rising edge.
   task automatic applyStimulus(input logic use1, input logic [3:0] r, input logic cin,
                                input logic [3:0] eg, input logic [1:0] es);
      if (use1) req1 = r;
      else      req4 = r;
      c = cin;
      pushExp(use1, eg, es);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic expectNow(input logic use1, input logic [3:0] eg, input logic [1:0] es);
      #1;
      pushExp(use1, eg, es);
      checkOutput();
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      expectNow(1'b0, 4'b0000, 2'd0);
      expectNow(1'b1, 4'b0000, 2'd0);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      c    = 1'b0;
      req4 = 4'b0000;
      req1 = 4'b0000;
      #12;
      $display("[TB] reset state");
      expectNow(1'b0, 4'b0000, 2'd0);
      expectNow(1'b1, 4'b0000, 2'd0);
      rst = 1'b0;

      $display("[TB] reset mid-grant");
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2);
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2);
      pulseReset();
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2);

      $display("[TB] single requester");
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0);
         applyStimulus(1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0);
      end
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);

      $display("[TB] round-robin all requesting");
      pulseReset();
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 4'b1111, 1'b1, 4'(1) << (r % 4), 2'(r % 4));
         applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0000, 2'(r % 4));
      end
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);

      $display("[TB] early release");
      applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1);
      applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1);

      $display("[TB] routing on index 2");
      applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2);
      c = 1'b1;
      expectNow(1'b0, 4'b0100, 2'd2);
      c = 1'b0;
      expectNow(1'b0, 4'b0100, 2'd2);
      for (int k = 1; k < 4; k++)
         applyStimulus(1'b0, 4'b0100, k[0], 4'b0100, 2'd2);
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2);

      $display("[TB] hold of one cycle");
      applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0001, 2'd0);
      applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0000, 2'd0);
      applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0100, 2'd2);
      applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0000, 2'd2);
      applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0001, 2'd0);
      applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0000, 2'd0);
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0);

      if (sb.size() != 0) begin
         tests++;
         failures++;
         $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
